uart_rx_sipo: RTL

Serial-in/parallel-out UART receiver. It is the receive-side counterpart of the team's PISO-based UART transmitter. It accepts an 8N1 frame on a single serial line: start bit low, DATA_BITS data bits LSB-first, one stop bit high. It reassembles the data bits into a parallel byte and presents it to the host with a ready/read handshake, plus framing-error and overrun status.

---
 rtl/uart_rx_sipo.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_sipo.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM and a
// serial-in/parallel-out shift register with a ready/read host handshake.
module uart_rx_sipo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy,
    output logic [3:0]           count
);

    localparam int TW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BRK_WAIT
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [TW-1:0]        r_timer;
    logic [3:0]           r_count;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_data_valid;
    logic                 r_data_ready;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic                 w_timer_half;
    logic                 w_timer_last;
    logic                 w_timer_clr;
    logic                 w_sample_bit;
    logic                 w_count_clr;
    logic                 w_byte_done;
    logic                 w_frame_bad;

    // NOTE: the synchronizer resets to 1 so the line looks idle and no false
    // start edge is seen when reset is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    assign w_timer_half = (r_timer == TW'(CLKS_PER_BIT / 2 - 1));
    assign w_timer_last = (r_timer == TW'(CLKS_PER_BIT - 1));

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_clr  = 1'b0;
        w_sample_bit = 1'b0;
        w_count_clr  = 1'b0;
        w_byte_done  = 1'b0;
        w_frame_bad  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_timer_clr = 1'b1;
                if (!r_rx_s) w_state_nxt = S_START;
            end
            S_START: begin
                // Start bit must still be low at its midpoint, else it was a glitch.
                if (w_timer_half) begin
                    w_timer_clr = 1'b1;
                    if (r_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DATA;
                        w_count_clr = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_timer_last) begin
                    w_timer_clr  = 1'b1;
                    w_sample_bit = 1'b1;
                    if (r_count == 4'(DATA_BITS - 1)) w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_timer_last) begin
                    w_timer_clr = 1'b1;
                    if (r_rx_s) begin
                        w_byte_done = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_frame_bad = 1'b1;
                        w_state_nxt = S_BRK_WAIT;
                    end
                end
            end
            S_BRK_WAIT: begin
                w_timer_clr = 1'b1;
                if (r_rx_s) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer      <= '0;
            r_count      <= '0;
            r_shreg      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_data_ready <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_timer      <= w_timer_clr ? '0 : r_timer + 1'b1;
            r_data_valid <= w_byte_done;
            r_frame_err  <= w_frame_bad;

            if (w_count_clr)       r_count <= '0;
            else if (w_sample_bit) r_count <= r_count + 1'b1;

            if (w_sample_bit) r_shreg <= {r_rx_s, r_shreg[DATA_BITS-1:1]};

            // A read coinciding with a new byte retires the old byte, so no overrun.
            if (w_byte_done) begin
                r_data_out   <= r_shreg;
                r_data_ready <= 1'b1;
                if (r_data_ready && !rd) r_overrun <= 1'b1;
            end else if (rd) begin
                r_data_ready <= 1'b0;
                r_overrun    <= 1'b0;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign data_ready = r_data_ready;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state != S_IDLE);
    assign count      = r_count;

endmodule
